counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl.sv | 143 ++++++++++++++
 tb/tb_counter_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
//
// Purpose:
//    Sequencer for an external up-counter. An accepted start latches a terminal
//    count and a mode. The controller then clears the counter for one cycle and
//    enables it until its value reaches the terminal count. At that point it
//    emits a one-cycle done pulse and either goes idle (one-shot) or clears the
//    counter and runs again (auto-reload). Completed periods are counted, and a
//    start that cannot be honoured raises a sticky error flag.
//
// Ports:
//    clk         rising-edge clock
//    rst_n       asynchronous active-low reset
//    start       run request (honoured only in IDLE with a non-zero tc)
//    stop        abort request; beats both start and terminal detection
//    pause       level, freezes counting while high
//    mode        0 = one-shot, 1 = auto-reload; latched on an accepted start
//    tc          terminal count; latched on an accepted start
//    cnt_q       current value of the external counter
//    cnt_clr     synchronous clear to the external counter
//    cnt_en      count enable to the external counter
//    busy        high whenever the controller is not IDLE
//    done        registered one-cycle pulse per completed period
//    period_cnt  completed periods since the last accepted start (saturating)
//    err         sticky flag for a rejected start
// -----------------------------------------------------------------------------
module counter_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             mode,
   input  logic [WIDTH-1:0] tc,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             cnt_clr,
   output logic             cnt_en,
   output logic             busy,
   output logic             done,
   output logic [7:0]       period_cnt,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] tc_reg;
   logic             mode_reg;
   logic             terminal;

   // Use >= rather than == so that a counter that has already passed the
   // terminal value still ends the period instead of wrapping forever.
   assign terminal = (cnt_q >= tc_reg);

   // Counter controls come straight from the state register, pause and the
   // compare. CLEAR and RUN are exclusive states, so clear and enable can
   // never be high in the same cycle. Because the state resets asynchronously,
   // these outputs also drop as soon as reset is asserted.
   always_comb begin
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      busy    = 1'b0;
      if (state == CLEAR) begin
         cnt_clr = 1'b1;
      end
      if (state == RUN) begin
         cnt_en = !pause && !terminal;
      end
      if (state != IDLE) begin
         busy = 1'b1;
      end
   end

   // Main sequencer: state, latched run parameters, done pulse, period count
   // and the sticky error flag. In every state, stop is checked before
   // anything else. In IDLE, a start that coincides with stop is dropped
   // without flagging an error. In CLEAR and RUN, stop aborts the run without
   // producing a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tc_reg     <= '0;
         mode_reg   <= 1'b0;
         done       <= 1'b0;
         period_cnt <= 8'd0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  if (tc != '0) begin
                     tc_reg     <= tc;
                     mode_reg   <= mode;
                     period_cnt <= 8'd0;
                     err        <= 1'b0;
                     state      <= CLEAR;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               if (stop) begin
                  state <= IDLE;
               end else begin
                  if (start) begin
                     err <= 1'b1;
                  end
                  state <= RUN;
               end
            end
            RUN: begin
               if (stop) begin
                  state <= IDLE;
               end else begin
                  if (start) begin
                     err <= 1'b1;
                  end
                  if (terminal) begin
                     if (period_cnt != 8'hFF) begin
                        period_cnt <= period_cnt + 8'd1;
                     end
                     done  <= 1'b1;
                     state <= mode_reg ? CLEAR : IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_ctrl
//
// Directed bench for counter_ctrl. The bench holds a behavioural external
// counter, drives the inputs on falling clock edges and samples the outputs on
// falling edges. Step numbers count the rising edges that follow the rising
// edge accepting a start: step 0 is the falling edge right after that
// accepting edge.
// -----------------------------------------------------------------------------
module tb_counter_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       pause;
   logic       mode;
   logic [3:0] tc;
   logic [3:0] cnt_q;
   logic       cnt_clr;
   logic       cnt_en;
   logic       busy;
   logic       done;
   logic [7:0] period_cnt;
   logic       err;

   int compared   = 0;
   int mismatched = 0;
   int step;
   int pulses;

   counter_ctrl #(.WIDTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .pause      (pause),
      .mode       (mode),
      .tc         (tc),
      .cnt_q      (cnt_q),
      .cnt_clr    (cnt_clr),
      .cnt_en     (cnt_en),
      .busy       (busy),
      .done       (done),
      .period_cnt (period_cnt),
      .err        (err)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model of the external counter that the controller steers:
   // clear has priority, and otherwise the counter adds one per enabled edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
      end else if (cnt_clr) begin
         cnt_q <= 4'd0;
      end else if (cnt_en) begin
         cnt_q <= cnt_q + 4'd1;
      end
   end

   // Drive every control input in a single call.
   task automatic applyStimulus(input logic s, input logic sp, input logic p,
                                input logic m, input logic [3:0] t);
      start = s;
      stop  = sp;
      pause = p;
      mode  = m;
      tc    = t;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance falling edges until done is seen or the step limit runs out.
   task automatic waitDone(input int from_step, input int limit, output int at_step);
      at_step = from_step;
      while (done !== 1'b1 && at_step < limit) begin
         @(negedge clk);
         at_step++;
      end
   endtask

   // The whole directed sequence.
   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

      // ---- reset state ----
      $display("[TB] reset");
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_cnt_en", cnt_en, 0);
      checkOutput("rst_cnt_clr", cnt_clr, 0);
      checkOutput("rst_period", period_cnt, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- one-shot, tc=5 ----
      $display("[TB] one-shot tc=5");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
      checkOutput("os_clr_s0", cnt_clr, 1);
      checkOutput("os_en_s0", cnt_en, 0);
      checkOutput("os_busy_s0", busy, 1);
      @(negedge clk);
      checkOutput("os_clr_s1", cnt_clr, 0);
      checkOutput("os_en_s1", cnt_en, 1);
      waitDone(1, 40, step);
      checkOutput("os_done_step", step, 7);
      checkOutput("os_busy_at_done", busy, 0);
      checkOutput("os_period", period_cnt, 1);
      @(negedge clk);
      checkOutput("os_done_once", done, 0);
      repeat (3) @(negedge clk);
      checkOutput("os_en_after", cnt_en, 0);

      // ---- auto-reload, tc=3 ----
      $display("[TB] auto-reload tc=3");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
      for (int s = 1; s <= 22; s++) begin
         @(negedge clk);
         checkOutput($sformatf("ar_done_s%0d", s), done, (s % 5 == 0) ? 1 : 0);
      end
      checkOutput("ar_period", period_cnt, 4);
      checkOutput("ar_busy", busy, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      checkOutput("ar_stop_busy", busy, 0);
      checkOutput("ar_stop_period", period_cnt, 4);
      @(negedge clk);

      // ---- pause for 4 cycles at cnt_q=2 ----
      $display("[TB] pause");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
      repeat (3) @(negedge clk);
      checkOutput("pa_cnt_s3", cnt_q, 2);
      pause = 1'b1;
      for (int s = 4; s <= 7; s++) begin
         @(negedge clk);
         checkOutput($sformatf("pa_hold_s%0d", s), cnt_q, 2);
         checkOutput($sformatf("pa_en_s%0d", s), cnt_en, 0);
      end
      pause = 1'b0;
      waitDone(7, 40, step);
      checkOutput("pa_done_step", step, 11);
      @(negedge clk);

      // ---- stop in RUN at cnt_q=2 ----
      $display("[TB] stop in run");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
      repeat (3) @(negedge clk);
      checkOutput("st_cnt_s3", cnt_q, 2);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checkOutput("st_busy", busy, 0);
      checkOutput("st_cnt_en", cnt_en, 0);
      checkOutput("st_period", period_cnt, 0);
      pulses = 0;
      for (int s = 0; s < 10; s++) begin
         if (done === 1'b1) pulses++;
         @(negedge clk);
      end
      checkOutput("st_no_done", pulses, 0);

      // ---- error handling ----
      $display("[TB] errors");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
      @(negedge clk);
      start = 1'b0;
      checkOutput("er_busy_start", err, 1);
      checkOutput("er_busy_still", busy, 1);
      waitDone(1, 40, step);
      checkOutput("er_tc_kept", step, 6);
      @(negedge clk);
      checkOutput("er_sticky", err, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      checkOutput("er_tc0_err", err, 1);
      checkOutput("er_tc0_idle", busy, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
      checkOutput("er_clear", err, 0);
      checkOutput("er_valid_busy", busy, 1);
      waitDone(0, 40, step);
      checkOutput("er_valid_done", step, 4);
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
      checkOutput("er_startstop_busy", busy, 0);
      checkOutput("er_startstop_err", err, 0);

      // ---- asynchronous reset mid-RUN ----
      $display("[TB] async reset");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
      repeat (6) @(negedge clk);
      checkOutput("ar_pre_busy", busy, 1);
      checkOutput("ar_pre_en", cnt_en, 1);
      checkOutput("ar_pre_period", period_cnt, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("ar_rst_busy", busy, 0);
      checkOutput("ar_rst_en", cnt_en, 0);
      checkOutput("ar_rst_period", period_cnt, 0);
      checkOutput("ar_rst_clr", cnt_clr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int s = 0; s < 10; s++) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      checkOutput("ar_no_done", pulses, 0);
      checkOutput("ar_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
